cache_fill_arbiter: RTL and testbench

Sequences and shares the single multi-cycle main memory between the instruction cache and the data cache. Accepts I-cache block-fill requests, D-cache block-fill requests and D-cache write-through stores. Drives pipelined word requests to memory and streams returned words into the owning cache's data array. Generates the IF and MEM stall signals that freeze the pipeline while a miss or store is outstanding.

---
 rtl/wisc_mem_pkg.sv | 25 ++
 rtl/cache_fill_arbiter_if.sv | 65 ++++++
 rtl/fill_counter.sv | 36 +++
 rtl/cache_fill_arbiter.sv | 140 ++++++++++++++
 tb/tb_cache_fill_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wisc_mem_pkg.sv
// Shared encodings and sizing for the cache fill arbiter.
package wisc_mem_pkg;

   localparam int BLOCK_WORDS = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_FILL  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

   // Byte-offset bits inside a block of 16-bit words.
   function automatic int unsigned blk_off_mask(int unsigned words);
      return 2 * words - 1;
   endfunction

   localparam int unsigned BLK_OFF_MASK = blk_off_mask(BLOCK_WORDS);

endpackage

// File: rtl/cache_fill_arbiter_if.sv
// Cache, store and memory signals shared by the fill arbiter.
interface cache_fill_arbiter_if #(
   parameter int AWIDTH      = 16,
   parameter int DWIDTH      = 16,
   parameter int BLOCK_WORDS = 8
);
   localparam int WW = $clog2(BLOCK_WORDS);

   logic              icache_miss;
   logic [AWIDTH-1:0] icache_miss_addr;
   logic              dcache_miss;
   logic [AWIDTH-1:0] dcache_miss_addr;
   logic              dcache_wr;
   logic [AWIDTH-1:0] dcache_wr_addr;
   logic [DWIDTH-1:0] dcache_wr_data;

   logic              mem_enable;
   logic              mem_wr;
   logic [AWIDTH-1:0] mem_addr;
   logic [DWIDTH-1:0] mem_data_out;
   logic [DWIDTH-1:0] mem_data_in;
   logic              mem_data_valid;

   logic [DWIDTH-1:0] fill_data;
   logic [WW-1:0]     fill_word;
   logic              fill_we_i;
   logic              fill_we_d;
   logic              fill_done_i;
   logic              fill_done_d;
   logic              wr_ack;
   logic              stall_if;
   logic              stall_mem;
   logic              busy;

   modport master (
      input  icache_miss, icache_miss_addr,
      input  dcache_miss, dcache_miss_addr,
      input  dcache_wr, dcache_wr_addr,
      input  dcache_wr_data,
      input  mem_data_in, mem_data_valid,
      output mem_enable, mem_wr, mem_addr,
      output mem_data_out,
      output fill_data, fill_word,
      output fill_we_i, fill_we_d,
      output fill_done_i, fill_done_d,
      output wr_ack, stall_if, stall_mem,
      output busy
   );

   modport slave (
      output icache_miss, icache_miss_addr,
      output dcache_miss, dcache_miss_addr,
      output dcache_wr, dcache_wr_addr,
      output dcache_wr_data,
      output mem_data_in, mem_data_valid,
      input  mem_enable, mem_wr, mem_addr,
      input  mem_data_out,
      input  fill_data, fill_word,
      input  fill_we_i, fill_we_d,
      input  fill_done_i, fill_done_d,
      input  wr_ack, stall_if, stall_mem,
      input  busy
   );

endinterface

// File: rtl/fill_counter.sv
// Saturating up-counter with synchronous clear and terminal count.
module fill_counter #(
   parameter int W   = 4,
   parameter int MAX = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o,
   output logic         tc_o
);

   logic [W-1:0] cnt_q, cnt_d;

   assign tc_o  = (cnt_q == W'(MAX));
   assign cnt_o = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !tc_o) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/cache_fill_arbiter.sv
// Shares one pipelined memory between I-cache fills, D-cache fills
// and D-cache write-through stores; raises the pipeline stalls.
module cache_fill_arbiter #(
   parameter int AWIDTH      = 16,
   parameter int DWIDTH      = 16,
   parameter int BLOCK_WORDS = wisc_mem_pkg::BLOCK_WORDS
) (
   input logic                  clk,
   input logic                  rst,
   cache_fill_arbiter_if.master bus
);
   import wisc_mem_pkg::*;

   localparam int WW = $clog2(BLOCK_WORDS);
   localparam int CW = WW + 1;
   localparam logic [AWIDTH-1:0] OFF_MASK =
      AWIDTH'(blk_off_mask(BLOCK_WORDS));

   state_e            state_q, state_d;
   owner_e            owner_q, owner_d;
   logic [AWIDTH-1:0] base_q, base_d;

   logic [CW-1:0] issue_cnt, recv_cnt;
   logic          issue_tc, recv_tc;
   logic          in_fill, cnt_clr;
   logic          issue_en, recv_en, last_word;

   assign in_fill  = (state_q == ST_FILL);
   assign cnt_clr  = ~in_fill;
   assign issue_en = in_fill & ~issue_tc;
   assign recv_en  = in_fill & bus.mem_data_valid & ~recv_tc;
   assign last_word = recv_en &
      (recv_cnt == CW'(BLOCK_WORDS - 1));

   fill_counter #(.W(CW), .MAX(BLOCK_WORDS)) u_issue (
      .clk   (clk),
      .rst   (rst),
      .clr_i (cnt_clr),
      .en_i  (issue_en),
      .cnt_o (issue_cnt),
      .tc_o  (issue_tc)
   );

   fill_counter #(.W(CW), .MAX(BLOCK_WORDS)) u_recv (
      .clk   (clk),
      .rst   (rst),
      .clr_i (cnt_clr),
      .en_i  (recv_en),
      .cnt_o (recv_cnt),
      .tc_o  (recv_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         owner_q <= OWN_I;
         base_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         base_q  <= base_d;
      end
   end

   // D-side work wins so the MEM stage is released first.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      base_d  = base_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.dcache_miss) begin
               owner_d = OWN_D;
               base_d  = bus.dcache_miss_addr & ~OFF_MASK;
               state_d = ST_FILL;
            end else if (bus.dcache_wr) begin
               state_d = ST_WRITE;
            end else if (bus.icache_miss) begin
               owner_d = OWN_I;
               base_d  = bus.icache_miss_addr & ~OFF_MASK;
               state_d = ST_FILL;
            end
         end
         ST_WRITE: state_d = ST_IDLE;
         ST_FILL: begin
            if (last_word) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.mem_enable   = 1'b0;
      bus.mem_wr       = 1'b0;
      bus.mem_addr     = {AWIDTH{1'b0}};
      bus.mem_data_out = {DWIDTH{1'b0}};
      bus.fill_data    = {DWIDTH{1'b0}};
      bus.fill_word    = {WW{1'b0}};
      bus.fill_we_i    = 1'b0;
      bus.fill_we_d    = 1'b0;
      bus.fill_done_i  = 1'b0;
      bus.fill_done_d  = 1'b0;
      bus.wr_ack       = 1'b0;
      unique case (state_q)
         ST_IDLE: ;
         ST_WRITE: begin
            bus.mem_enable   = 1'b1;
            bus.mem_wr       = 1'b1;
            bus.mem_addr     = bus.dcache_wr_addr;
            bus.mem_data_out = bus.dcache_wr_data;
            bus.wr_ack       = 1'b1;
         end
         ST_FILL: begin
            if (issue_en) begin
               bus.mem_enable = 1'b1;
               bus.mem_addr   = base_q +
                  AWIDTH'({issue_cnt, 1'b0});
            end
            if (recv_en) begin
               bus.fill_data = bus.mem_data_in;
               bus.fill_word = recv_cnt[WW-1:0];
               bus.fill_we_i = (owner_q == OWN_I);
               bus.fill_we_d = (owner_q == OWN_D);
            end
         end
         ST_DONE: begin
            bus.fill_done_i = (owner_q == OWN_I);
            bus.fill_done_d = (owner_q == OWN_D);
         end
      endcase
   end

   assign bus.stall_if  = bus.icache_miss;
   assign bus.stall_mem = bus.dcache_miss |
      (bus.dcache_wr & ~bus.wr_ack);
   assign bus.busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter with a 4-cycle memory model.
module tb_cache_fill_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   cache_fill_arbiter_if bus ();

   cache_fill_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Read returns exactly four cycles after issue; data = addr ^ 5A5A.
   logic [3:0]  pv = 4'b0;
   logic [15:0] pa [4];

   always @(posedge clk) begin
      pv    <= {pv[2:0], bus.mem_enable & ~bus.mem_wr};
      pa[0] <= bus.mem_addr;
      pa[1] <= pa[0];
      pa[2] <= pa[1];
      pa[3] <= pa[2];
   end

   assign bus.mem_data_valid = pv[3];
   assign bus.mem_data_in = pv[3] ? (pa[3] ^ 16'h5A5A) : 16'h0;

   function automatic logic [34:0] mem_obs();
      return {bus.mem_enable, bus.mem_wr, bus.mem_addr,
              bus.mem_data_out, bus.wr_ack};
   endfunction

   function automatic logic [23:0] fill_obs();
      return {bus.fill_we_i, bus.fill_we_d, bus.fill_word,
              bus.fill_data, bus.fill_done_i, bus.fill_done_d,
              bus.busy};
   endfunction

   // k = cycles since entering FILL (k=0 is the first issue).
   function automatic logic [34:0] mem_exp(int k, logic [15:0] base);
      if (k >= 0 && k < 8) begin
         return {2'b10, base + 16'(2 * k), 16'h0, 1'b0};
      end
      return '0;
   endfunction

   function automatic logic [23:0] fill_exp(int k, logic [15:0] base,
                                            logic d);
      logic        we;
      logic [2:0]  w;
      logic [15:0] dat;
      we  = (k >= 4 && k < 12);
      w   = we ? 3'(k - 4) : 3'd0;
      dat = we ? ((base + 16'(2 * (k - 4))) ^ 16'h5A5A) : 16'h0;
      return {we & ~d, we & d, w, dat,
              (k == 12) & ~d, (k == 12) & d,
              (k >= 0 && k <= 12)};
   endfunction

   task automatic test_reset();
      bus.icache_miss      = 1'b1;
      bus.icache_miss_addr = 16'h0;
      bus.dcache_miss      = 1'b0;
      bus.dcache_miss_addr = 16'h0;
      bus.dcache_wr        = 1'b0;
      bus.dcache_wr_addr   = 16'h0;
      bus.dcache_wr_data   = 16'h0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      checks += 3;
      if (mem_obs() !== 35'h0) begin
         failures++;
         $display("FAIL reset_mem got=%h exp=0", mem_obs());
      end
      if (fill_obs() !== 24'h0) begin
         failures++;
         $display("FAIL reset_fill got=%h exp=0", fill_obs());
      end
      if ({bus.stall_if, bus.stall_mem} !== 2'b10) begin
         failures++;
         $display("FAIL reset_stall got=%b exp=10",
                  {bus.stall_if, bus.stall_mem});
      end
      bus.icache_miss = 1'b0;
      bus.dcache_wr   = 1'b1;
      #1;
      checks++;
      if ({bus.stall_if, bus.stall_mem} !== 2'b01) begin
         failures++;
         $display("FAIL reset_stall_wr got=%b exp=01",
                  {bus.stall_if, bus.stall_mem});
      end
      bus.dcache_wr = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_imiss();
      logic [34:0] ea;
      logic [23:0] ef;
      for (int c = 0; c <= 14; c++) begin
         @(negedge clk);
         if (c == 0) begin
            bus.icache_miss      = 1'b1;
            bus.icache_miss_addr = 16'h1236;
         end
         if (c == 2) bus.icache_miss_addr = 16'h7770;
         if (c == 14) bus.icache_miss = 1'b0;
         #1;
         ea = mem_exp(c - 1, 16'h1230);
         ef = fill_exp(c - 1, 16'h1230, 1'b0);
         checks += 3;
         if (mem_obs() !== ea) begin
            failures++;
            $display("FAIL imiss_mem c=%0d got=%h exp=%h",
                     c, mem_obs(), ea);
         end
         if (fill_obs() !== ef) begin
            failures++;
            $display("FAIL imiss_fill c=%0d got=%h exp=%h",
                     c, fill_obs(), ef);
         end
         if ({bus.stall_if, bus.stall_mem} !==
             {bus.icache_miss, 1'b0}) begin
            failures++;
            $display("FAIL imiss_stall c=%0d got=%b exp=%b", c,
                     {bus.stall_if, bus.stall_mem},
                     {bus.icache_miss, 1'b0});
         end
      end
   endtask

   task automatic test_simul();
      logic [34:0] ea;
      logic [23:0] ef;
      for (int c = 0; c <= 28; c++) begin
         @(negedge clk);
         if (c == 0) begin
            bus.icache_miss      = 1'b1;
            bus.icache_miss_addr = 16'h0040;
            bus.dcache_miss      = 1'b1;
            bus.dcache_miss_addr = 16'h8012;
         end
         if (c == 14) bus.dcache_miss = 1'b0;
         if (c == 28) bus.icache_miss = 1'b0;
         #1;
         ea = mem_exp(c - 1, 16'h8010) | mem_exp(c - 15, 16'h0040);
         ef = fill_exp(c - 1, 16'h8010, 1'b1) |
              fill_exp(c - 15, 16'h0040, 1'b0);
         checks += 3;
         if (mem_obs() !== ea) begin
            failures++;
            $display("FAIL simul_mem c=%0d got=%h exp=%h",
                     c, mem_obs(), ea);
         end
         if (fill_obs() !== ef) begin
            failures++;
            $display("FAIL simul_fill c=%0d got=%h exp=%h",
                     c, fill_obs(), ef);
         end
         if ({bus.stall_if, bus.stall_mem} !==
             {bus.icache_miss, bus.dcache_miss}) begin
            failures++;
            $display("FAIL simul_stall c=%0d got=%b exp=%b", c,
                     {bus.stall_if, bus.stall_mem},
                     {bus.icache_miss, bus.dcache_miss});
         end
      end
   endtask

   task automatic test_store();
      logic [34:0] ea;
      logic [23:0] ef;
      for (int c = 0; c <= 16; c++) begin
         @(negedge clk);
         if (c == 0) begin
            bus.dcache_wr        = 1'b1;
            bus.dcache_wr_addr   = 16'h0100;
            bus.dcache_wr_data   = 16'hBEEF;
            bus.icache_miss      = 1'b1;
            bus.icache_miss_addr = 16'h0222;
         end
         if (c == 2) bus.dcache_wr = 1'b0;
         if (c == 16) bus.icache_miss = 1'b0;
         #1;
         if (c == 1) begin
            ea = {2'b11, 16'h0100, 16'hBEEF, 1'b1};
            ef = 24'h000001;
         end else begin
            ea = mem_exp(c - 3, 16'h0220);
            ef = fill_exp(c - 3, 16'h0220, 1'b0);
         end
         checks += 3;
         if (mem_obs() !== ea) begin
            failures++;
            $display("FAIL store_mem c=%0d got=%h exp=%h",
                     c, mem_obs(), ea);
         end
         if (fill_obs() !== ef) begin
            failures++;
            $display("FAIL store_fill c=%0d got=%h exp=%h",
                     c, fill_obs(), ef);
         end
         if ({bus.stall_if, bus.stall_mem} !==
             {bus.icache_miss, bus.dcache_wr & ~ea[0]}) begin
            failures++;
            $display("FAIL store_stall c=%0d got=%b exp=%b", c,
                     {bus.stall_if, bus.stall_mem},
                     {bus.icache_miss, bus.dcache_wr & ~ea[0]});
         end
      end
   endtask

   task automatic test_wrap();
      logic [34:0] ea;
      logic [23:0] ef;
      for (int c = 0; c <= 14; c++) begin
         @(negedge clk);
         if (c == 0) begin
            bus.dcache_miss      = 1'b1;
            bus.dcache_miss_addr = 16'hFFFA;
         end
         if (c == 14) bus.dcache_miss = 1'b0;
         #1;
         ea = mem_exp(c - 1, 16'hFFF0);
         ef = fill_exp(c - 1, 16'hFFF0, 1'b1);
         checks += 2;
         if (mem_obs() !== ea) begin
            failures++;
            $display("FAIL wrap_mem c=%0d got=%h exp=%h",
                     c, mem_obs(), ea);
         end
         if (fill_obs() !== ef) begin
            failures++;
            $display("FAIL wrap_fill c=%0d got=%h exp=%h",
                     c, fill_obs(), ef);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [34:0] ea;
      logic [23:0] ef;
      for (int c = 0; c <= 12; c++) begin
         @(negedge clk);
         if (c == 0) begin
            bus.dcache_miss      = 1'b1;
            bus.dcache_miss_addr = 16'h3004;
         end
         if (c == 6) begin
            rst             = 1'b1;
            bus.dcache_miss = 1'b0;
         end
         if (c == 7) rst = 1'b0;
         #1;
         ea = (c <= 6) ? mem_exp(c - 1, 16'h3000) : 35'h0;
         ef = (c <= 6) ? fill_exp(c - 1, 16'h3000, 1'b1) : 24'h0;
         checks += 3;
         if (mem_obs() !== ea) begin
            failures++;
            $display("FAIL rstmid_mem c=%0d got=%h exp=%h",
                     c, mem_obs(), ea);
         end
         if (fill_obs() !== ef) begin
            failures++;
            $display("FAIL rstmid_fill c=%0d got=%h exp=%h",
                     c, fill_obs(), ef);
         end
         if (bus.stall_mem !== bus.dcache_miss) begin
            failures++;
            $display("FAIL rstmid_stall c=%0d got=%b exp=%b",
                     c, bus.stall_mem, bus.dcache_miss);
         end
      end
   endtask

   task automatic test_drop();
      logic [34:0] ea;
      logic [23:0] ef;
      for (int c = 0; c <= 14; c++) begin
         @(negedge clk);
         if (c == 0) begin
            bus.icache_miss      = 1'b1;
            bus.icache_miss_addr = 16'h0A0E;
         end
         if (c == 3) bus.icache_miss = 1'b0;
         #1;
         ea = mem_exp(c - 1, 16'h0A00);
         ef = fill_exp(c - 1, 16'h0A00, 1'b0);
         checks += 3;
         if (mem_obs() !== ea) begin
            failures++;
            $display("FAIL drop_mem c=%0d got=%h exp=%h",
                     c, mem_obs(), ea);
         end
         if (fill_obs() !== ef) begin
            failures++;
            $display("FAIL drop_fill c=%0d got=%h exp=%h",
                     c, fill_obs(), ef);
         end
         if (bus.stall_if !== bus.icache_miss) begin
            failures++;
            $display("FAIL drop_stall c=%0d got=%b exp=%b",
                     c, bus.stall_if, bus.icache_miss);
         end
      end
   endtask

   initial begin
      test_reset();
      test_imiss();
      test_simul();
      test_store();
      test_wrap();
      test_reset_mid();
      test_drop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

endmodule
